// File: rtl/sw_avm_stream_wrapper.sv
// Avalon-MM master that polls the UART for a length header plus two packed
// base sequences, hands the job to a Smith-Waterman core over valid/ready,
// and returns a 7-byte result frame (status, col, row, score) over the UART.
//
// state        | meaning
// S_QUERY_RX   | status read outstanding, waiting for RX_OK
// S_READ       | RX data read outstanding, store byte on completion
// S_CHECK      | validate header lengths (one cycle)
// S_CORE_REQ   | job offered to core, waiting for core_ready
// S_CORE_WAIT  | waiting for core result
// S_QUERY_TX   | status read outstanding, waiting for TX_OK
// S_WRITE      | TX data write outstanding
// S_DONE       | pulse job_done, clear job state, resume RX polling
module sw_avm_stream_wrapper #(
  parameter int REF_MAX_LENGTH  = 128,
  parameter int READ_MAX_LENGTH = 128,
  parameter int SCORE_W         = 10,
  parameter int POS_W           = 7
) (
  input  logic                         avm_clk,
  input  logic                         avm_rst,
  output logic [4:0]                   avm_address,
  output logic                         avm_read,
  input  logic [31:0]                  avm_readdata,
  output logic                         avm_write,
  output logic [31:0]                  avm_writedata,
  input  logic                         avm_waitrequest,
  output logic                         core_valid,
  input  logic                         core_ready,
  output logic [2*REF_MAX_LENGTH-1:0]  core_ref,
  output logic [2*READ_MAX_LENGTH-1:0] core_read,
  output logic [7:0]                   core_ref_len,
  output logic [7:0]                   core_read_len,
  input  logic                         core_res_valid,
  output logic                         core_res_ready,
  input  logic [SCORE_W-1:0]           core_score,
  input  logic [POS_W-1:0]             core_row,
  input  logic [POS_W-1:0]             core_col,
  output logic                         job_done
);

  localparam int REF_W      = 2 * REF_MAX_LENGTH;
  localparam int READ_W     = 2 * READ_MAX_LENGTH;
  localparam int REF_BYTES  = REF_MAX_LENGTH / 4;
  localparam int READ_BYTES = READ_MAX_LENGTH / 4;
  localparam int RX_BYTES   = 2 + REF_BYTES + READ_BYTES;
  localparam int TX_BYTES   = 7;
  localparam int CNT_W      = $clog2(RX_BYTES + 1);

  localparam logic [4:0] ADDR_RX     = 5'd0;
  localparam logic [4:0] ADDR_TX     = 5'd4;
  localparam logic [4:0] ADDR_STATUS = 5'd8;

  localparam logic [CNT_W-1:0] CNT_LAST_RX = CNT_W'(RX_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_REF_END = CNT_W'(2 + REF_BYTES);
  localparam logic [CNT_W-1:0] CNT_LAST_TX = CNT_W'(TX_BYTES - 1);
  localparam logic [31:0]      REF_MAX_U   = 32'(REF_MAX_LENGTH);
  localparam logic [31:0]      READ_MAX_U  = 32'(READ_MAX_LENGTH);

  typedef enum logic [2:0] {
    S_QUERY_RX, S_READ, S_CHECK, S_CORE_REQ,
    S_CORE_WAIT, S_QUERY_TX, S_WRITE, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               avm_read_q, avm_read_d;
  logic               avm_write_q, avm_write_d;
  logic [4:0]         avm_address_q, avm_address_d;
  logic [31:0]        avm_writedata_q, avm_writedata_d;
  logic [REF_W-1:0]   ref_q, ref_d;
  logic [READ_W-1:0]  read_q, read_d;
  logic [7:0]         ref_len_q, ref_len_d;
  logic [7:0]         read_len_q, read_len_d;
  logic [55:0]        result_q, result_d;
  logic               core_valid_q, core_valid_d;
  logic               core_res_ready_q, core_res_ready_d;
  logic               job_done_q, job_done_d;

  logic [7:0]  rx_byte;
  logic        rx_ok, tx_ok, len_err;
  logic [15:0] score_ext, row_ext, col_ext;
  logic [23:0] rd_unused;

  assign rx_byte   = avm_readdata[7:0];
  assign rx_ok     = avm_readdata[7];
  assign tx_ok     = avm_readdata[6];
  assign rd_unused = avm_readdata[31:8];

  assign score_ext = 16'($signed(core_score));
  assign row_ext   = 16'(core_row);
  assign col_ext   = 16'(core_col);

  assign len_err = (ref_len_q == 8'd0) || ({24'd0, ref_len_q} > REF_MAX_U) ||
                   (read_len_q == 8'd0) || ({24'd0, read_len_q} > READ_MAX_U);

  // Next-state and next-output computation; every Avalon and core output is
  // taken straight from a flop so nothing depends combinationally on a partner.
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    avm_read_d       = avm_read_q;
    avm_write_d      = avm_write_q;
    avm_address_d    = avm_address_q;
    avm_writedata_d  = avm_writedata_q;
    ref_d            = ref_q;
    read_d           = read_q;
    ref_len_d        = ref_len_q;
    read_len_d       = read_len_q;
    result_d         = result_q;
    core_valid_d     = core_valid_q;
    core_res_ready_d = core_res_ready_q;
    job_done_d       = 1'b0;

    case (state_q)
      S_QUERY_RX: begin
        if (!avm_waitrequest && rx_ok) begin
          avm_address_d = ADDR_RX;
          state_d       = S_READ;
        end
      end

      S_READ: begin
        if (!avm_waitrequest) begin
          if (cnt_q == '0)                     ref_len_d  = rx_byte;
          else if (cnt_q == CNT_W'(1))         read_len_d = rx_byte;
          else if (cnt_q < CNT_REF_END)        ref_d      = {ref_q[REF_W-9:0], rx_byte};
          else                                 read_d     = {read_q[READ_W-9:0], rx_byte};
          cnt_d         = cnt_q + CNT_W'(1);
          avm_address_d = ADDR_STATUS;
          state_d       = (cnt_q == CNT_LAST_RX) ? S_CHECK : S_QUERY_RX;
        end
      end

      // The trailing status read from S_READ is allowed to finish here and
      // then dropped; the counter is reused to index TX bytes.
      S_CHECK: begin
        if (!avm_waitrequest) avm_read_d = 1'b0;
        cnt_d = '0;
        if (len_err) begin
          result_d      = {8'h01, 48'd0};
          avm_read_d    = 1'b1;
          avm_address_d = ADDR_STATUS;
          state_d       = S_QUERY_TX;
        end else begin
          core_valid_d = 1'b1;
          state_d      = S_CORE_REQ;
        end
      end

      S_CORE_REQ: begin
        if (!avm_waitrequest) avm_read_d = 1'b0;
        if (core_ready) begin
          core_valid_d     = 1'b0;
          core_res_ready_d = 1'b1;
          state_d          = S_CORE_WAIT;
        end
      end

      S_CORE_WAIT: begin
        if (!avm_waitrequest) avm_read_d = 1'b0;
        if (core_res_valid) begin
          core_res_ready_d = 1'b0;
          result_d         = {8'h00, col_ext, row_ext, score_ext};
          avm_read_d       = 1'b1;
          avm_address_d    = ADDR_STATUS;
          state_d          = S_QUERY_TX;
        end
      end

      S_QUERY_TX: begin
        if (!avm_waitrequest && tx_ok) begin
          avm_read_d      = 1'b0;
          avm_write_d     = 1'b1;
          avm_address_d   = ADDR_TX;
          avm_writedata_d = {24'd0, result_q[55:48]};
          state_d         = S_WRITE;
        end
      end

      S_WRITE: begin
        if (!avm_waitrequest) begin
          avm_write_d     = 1'b0;
          avm_writedata_d = 32'd0;
          avm_read_d      = 1'b1;
          avm_address_d   = ADDR_STATUS;
          result_d        = {result_q[47:0], 8'd0};
          cnt_d           = cnt_q + CNT_W'(1);
          state_d         = (cnt_q == CNT_LAST_TX) ? S_DONE : S_QUERY_TX;
        end
      end

      S_DONE: begin
        job_done_d    = 1'b1;
        ref_d         = '0;
        read_d        = '0;
        ref_len_d     = 8'd0;
        read_len_d    = 8'd0;
        result_d      = 56'd0;
        cnt_d         = '0;
        avm_read_d    = 1'b1;
        avm_address_d = ADDR_STATUS;
        state_d       = S_QUERY_RX;
      end

      default: state_d = S_QUERY_RX;
    endcase
  end

  // State and output registers; reset leaves a status read pending.
  always_ff @(posedge avm_clk or posedge avm_rst) begin
    if (avm_rst) begin
      state_q          <= S_QUERY_RX;
      cnt_q            <= '0;
      avm_read_q       <= 1'b1;
      avm_write_q      <= 1'b0;
      avm_address_q    <= ADDR_STATUS;
      avm_writedata_q  <= 32'd0;
      ref_q            <= '0;
      read_q           <= '0;
      ref_len_q        <= 8'd0;
      read_len_q       <= 8'd0;
      result_q         <= 56'd0;
      core_valid_q     <= 1'b0;
      core_res_ready_q <= 1'b0;
      job_done_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      avm_read_q       <= avm_read_d;
      avm_write_q      <= avm_write_d;
      avm_address_q    <= avm_address_d;
      avm_writedata_q  <= avm_writedata_d;
      ref_q            <= ref_d;
      read_q           <= read_d;
      ref_len_q        <= ref_len_d;
      read_len_q       <= read_len_d;
      result_q         <= result_d;
      core_valid_q     <= core_valid_d;
      core_res_ready_q <= core_res_ready_d;
      job_done_q       <= job_done_d;
    end
  end

  assign avm_read       = avm_read_q;
  assign avm_write      = avm_write_q;
  assign avm_address    = avm_address_q;
  assign avm_writedata  = avm_writedata_q;
  assign core_valid     = core_valid_q;
  assign core_res_ready = core_res_ready_q;
  assign core_ref       = ref_q;
  assign core_read      = read_q;
  assign core_ref_len   = ref_len_q;
  assign core_read_len  = read_len_q;
  assign job_done       = job_done_q;

endmodule

// File: tb/tb_sw_avm_stream_wrapper.sv
// Bench for sw_avm_stream_wrapper: UART slave model feeding RX frames, a
// core model checking each job, and a TX scoreboard comparing result bytes.
module tb_sw_avm_stream_wrapper;

  localparam int REF_MAX  = 128;
  localparam int READ_MAX = 128;
  localparam int SCORE_W  = 10;
  localparam int POS_W    = 7;

  logic                  avm_clk = 1'b0;
  logic                  avm_rst = 1'b1;
  logic [4:0]            avm_address;
  logic                  avm_read;
  logic [31:0]           avm_readdata;
  logic                  avm_write;
  logic [31:0]           avm_writedata;
  logic                  avm_waitrequest;
  logic                  core_valid;
  logic                  core_ready;
  logic [2*REF_MAX-1:0]  core_ref;
  logic [2*READ_MAX-1:0] core_read;
  logic [7:0]            core_ref_len;
  logic [7:0]            core_read_len;
  logic                  core_res_valid;
  logic                  core_res_ready;
  logic [SCORE_W-1:0]    core_score;
  logic [POS_W-1:0]      core_row;
  logic [POS_W-1:0]      core_col;
  logic                  job_done;

  always #5 avm_clk = ~avm_clk;

  sw_avm_stream_wrapper #(
    .REF_MAX_LENGTH(REF_MAX), .READ_MAX_LENGTH(READ_MAX),
    .SCORE_W(SCORE_W), .POS_W(POS_W)
  ) dut (
    .avm_clk(avm_clk), .avm_rst(avm_rst),
    .avm_address(avm_address), .avm_read(avm_read), .avm_readdata(avm_readdata),
    .avm_write(avm_write), .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
    .core_valid(core_valid), .core_ready(core_ready),
    .core_ref(core_ref), .core_read(core_read),
    .core_ref_len(core_ref_len), .core_read_len(core_read_len),
    .core_res_valid(core_res_valid), .core_res_ready(core_res_ready),
    .core_score(core_score), .core_row(core_row), .core_col(core_col),
    .job_done(job_done)
  );

  typedef struct {
    logic [7:0]         rl, dl, rb, db;
    logic [SCORE_W-1:0] score;
    logic [POS_W-1:0]   row, col;
    int                 rdy_dly, res_dly;
  } job_t;

  int         checks   = 0;
  int         errors   = 0;
  int         done_cnt = 0;
  bit         rand_en  = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_tx[$];
  job_t       jobs[$];
  event       tx_ev;
  logic [7:0] tx_byte;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] rl, input logic [7:0] dl,
                            input logic [7:0] rb, input logic [7:0] db);
    rx_q.push_back(rl);
    rx_q.push_back(dl);
    repeat (REF_MAX / 4) rx_q.push_back(rb);
    repeat (READ_MAX / 4) rx_q.push_back(db);
  endtask

  task automatic expect_tx(input logic [55:0] f);
    for (int i = 0; i < 7; i++) exp_tx.push_back(f[55 - 8 * i -: 8]);
  endtask

  task automatic expect_job(input logic [7:0] rl, input logic [7:0] dl,
                            input logic [7:0] rb, input logic [7:0] db,
                            input logic [SCORE_W-1:0] sc, input logic [POS_W-1:0] row,
                            input logic [POS_W-1:0] col, input int rdy, input int res);
    job_t j;
    j.rl = rl; j.dl = dl; j.rb = rb; j.db = db;
    j.score = sc; j.row = row; j.col = col; j.rdy_dly = rdy; j.res_dly = res;
    jobs.push_back(j);
  endtask

  task automatic wait_done(input int n);
    int g;
    g = 0;
    while (done_cnt < n && g < 8000) begin
      @(negedge avm_clk);
      g++;
    end
    repeat (3) @(negedge avm_clk);
    chk("job_done_count", 256'(done_cnt), 256'(n));
    chk("tx_all_sent", 256'(exp_tx.size()), 256'(0));
    chk("jobs_consumed", 256'(jobs.size()), 256'(0));
  endtask

  // UART slave: random waitrequest, RX/TX readiness stalls, command-hold check.
  initial begin
    logic        w, pw, rxok, txok;
    logic [38:0] pcmd;
    avm_waitrequest = 1'b0;
    avm_readdata    = 32'd0;
    pw              = 1'b0;
    pcmd            = '0;
    forever begin
      @(negedge avm_clk);
      if (avm_rst) begin
        pw = 1'b0;
        avm_waitrequest = 1'b0;
        avm_readdata = 32'd0;
      end else begin
        if (pw) chk("cmd_held", 256'({avm_read, avm_write, avm_address, avm_writedata}), 256'(pcmd));
        w    = rand_en ? ($urandom_range(0, 1) == 1) : 1'b0;
        rxok = (rx_q.size() > 0) && (!rand_en || $urandom_range(0, 3) != 0);
        txok = !rand_en || ($urandom_range(0, 2) != 0);
        avm_waitrequest = w;
        avm_readdata = w ? 32'hFFFF_FFFF : 32'd0;
        if (avm_read && !w) begin
          if (avm_address == 5'd8) avm_readdata = {24'd0, rxok, txok, 6'd0};
          else if (avm_address == 5'd0) begin
            if (rx_q.size() > 0) avm_readdata = {24'd0, rx_q.pop_front()};
            else begin
              checks++; errors++;
              $display("FAIL rx_underflow actual=read_with_empty_fifo required=no_read");
            end
          end else chk("read_addr", 256'(avm_address), 256'(8));
        end
        if (avm_write && !w) begin
          chk("write_addr", 256'(avm_address), 256'(4));
          chk("write_upper", 256'(avm_writedata[31:8]), 256'(0));
          tx_byte = avm_writedata[7:0];
          -> tx_ev;
        end
        pw   = w && (avm_read || avm_write);
        pcmd = {avm_read, avm_write, avm_address, avm_writedata};
      end
    end
  end

  // TX scoreboard monitor.
  initial begin
    forever begin
      @(tx_ev);
      if (exp_tx.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx_unexpected actual=%0h required=none", tx_byte);
      end else chk("tx_byte", 256'(tx_byte), 256'(exp_tx.pop_front()));
    end
  end

  // job_done pulse counter.
  initial begin
    forever begin
      @(negedge avm_clk);
      if (!avm_rst && job_done) done_cnt++;
    end
  end

  // Core model: checks each offered job, then returns the programmed result.
  initial begin
    job_t j;
    int   g;
    core_ready = 1'b0; core_res_valid = 1'b0;
    core_score = '0; core_row = '0; core_col = '0;
    forever begin
      @(negedge avm_clk);
      if (!avm_rst && core_valid) begin
        if (jobs.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_core_valid actual=1 required=0");
        end else begin
          j = jobs.pop_front();
          for (int i = 0; i < j.rdy_dly; i++) begin
            chk("core_valid_held", 256'(core_valid), 256'(1));
            @(negedge avm_clk);
          end
          core_ready = 1'b1;
          chk("core_valid_at_xfer", 256'(core_valid), 256'(1));
          chk("core_ref_len", 256'(core_ref_len), 256'(j.rl));
          chk("core_read_len", 256'(core_read_len), 256'(j.dl));
          chk("core_ref", core_ref, {32{j.rb}});
          chk("core_read", core_read, {32{j.db}});
          @(negedge avm_clk);
          core_ready = 1'b0;
          chk("core_valid_single", 256'(core_valid), 256'(0));
          repeat (j.res_dly) @(negedge avm_clk);
          core_score = j.score; core_row = j.row; core_col = j.col;
          core_res_valid = 1'b1;
          g = 0;
          while (!core_res_ready && g < 1000) begin
            @(negedge avm_clk);
            g++;
          end
          chk("core_res_ready", 256'(core_res_ready), 256'(1));
          @(negedge avm_clk);
          core_res_valid = 1'b0;
          core_score = '0; core_row = '0; core_col = '0;
        end
      end
    end
  end

  // Directed sequence.
  initial begin
    int g;
    avm_rst = 1'b1;
    @(posedge avm_clk);
    #1;
    chk("rst_avm_read", 256'(avm_read), 256'(1));
    chk("rst_avm_addr", 256'(avm_address), 256'(8));
    chk("rst_avm_write", 256'(avm_write), 256'(0));
    chk("rst_core_valid", 256'(core_valid), 256'(0));
    chk("rst_res_ready", 256'(core_res_ready), 256'(0));
    chk("rst_job_done", 256'(job_done), 256'(0));
    repeat (2) @(negedge avm_clk);
    avm_rst = 1'b0;

    // Full-length job, UART always ready: score -3, row 5, col 9.
    expect_job(8'd128, 8'd128, 8'h1B, 8'hE4, 10'h3FD, 7'd5, 7'd9, 0, 3);
    expect_tx(56'h00_0009_0005_FFFD);
    send_frame(8'd128, 8'd128, 8'h1B, 8'hE4);
    wait_done(1);

    // ref_len = 0 -> error frame, no core job.
    expect_tx(56'h01_0000_0000_0000);
    send_frame(8'd0, 8'd64, 8'h11, 8'h22);
    wait_done(2);

    // Random bus stalls, slow core: score -16, row 127, col 64.
    rand_en = 1'b1;
    expect_job(8'd128, 8'd128, 8'h6C, 8'h93, 10'h3F0, 7'd127, 7'd64, 20, 100);
    expect_tx(56'h00_0040_007F_FFF0);
    send_frame(8'd128, 8'd128, 8'h6C, 8'h93);
    wait_done(3);

    // ref_len one past maximum.
    expect_tx(56'h01_0000_0000_0000);
    send_frame(8'd129, 8'd4, 8'hA5, 8'h5A);
    wait_done(4);

    // read_len one past maximum.
    expect_tx(56'h01_0000_0000_0000);
    send_frame(8'd64, 8'd129, 8'h0F, 8'hF0);
    wait_done(5);

    // Short legal lengths, max positive score 511, row 0, col 127.
    expect_job(8'd4, 8'd4, 8'hFF, 8'h00, 10'h1FF, 7'd0, 7'd127, 2, 5);
    expect_tx(56'h00_007F_0000_01FF);
    send_frame(8'd4, 8'd4, 8'hFF, 8'h00);
    wait_done(6);

    // Reset after 10 RX bytes: partial frame discarded.
    rx_q.push_back(8'd128);
    rx_q.push_back(8'd128);
    repeat (8) rx_q.push_back(8'h55);
    g = 0;
    while (rx_q.size() > 0 && g < 4000) begin
      @(negedge avm_clk);
      g++;
    end
    chk("partial_consumed", 256'(rx_q.size()), 256'(0));
    @(negedge avm_clk);
    #2 avm_rst = 1'b1;
    #1;
    chk("mid_rst_avm_read", 256'(avm_read), 256'(1));
    chk("mid_rst_avm_addr", 256'(avm_address), 256'(8));
    chk("mid_rst_avm_write", 256'(avm_write), 256'(0));
    chk("mid_rst_core_valid", 256'(core_valid), 256'(0));
    chk("mid_rst_ref", core_ref, 256'(0));
    chk("mid_rst_ref_len", 256'(core_ref_len), 256'(0));
    repeat (2) @(negedge avm_clk);
    avm_rst = 1'b0;

    expect_job(8'd128, 8'd128, 8'h1B, 8'hE4, 10'h003, 7'd1, 7'd2, 1, 2);
    expect_tx(56'h00_0002_0001_0003);
    send_frame(8'd128, 8'd128, 8'h1B, 8'hE4);
    wait_done(7);

    repeat (20) @(negedge avm_clk);
    chk("final_job_done_count", 256'(done_cnt), 256'(7));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
